// File: rtl/alu_181_serial_if.sv
// Bus bundle for alu_181_serial: start/ready/busy/done handshake, operands, result and flags.
// ALU_181_OVF_EN adds the overflow_o flag.
interface alu_181_serial_if #(parameter int WIDTH = 16);
    logic             start_i;
    logic [3:0]       S_selection_i;
    logic             mode_control_i;
    logic             carry_in_i;
    logic [WIDTH-1:0] A_i;
    logic [WIDTH-1:0] B_i;
    logic             ready_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] F_o;
    logic             carry_output_o;
    logic             equality_o;
    logic             zero_o;
`ifdef ALU_181_OVF_EN
    logic             overflow_o;

    modport slave (
        input  start_i, S_selection_i, mode_control_i, carry_in_i, A_i, B_i,
        output ready_o, busy_o, done_o, F_o, carry_output_o, equality_o, zero_o, overflow_o
    );
    modport master (
        output start_i, S_selection_i, mode_control_i, carry_in_i, A_i, B_i,
        input  ready_o, busy_o, done_o, F_o, carry_output_o, equality_o, zero_o, overflow_o
    );
`else
    modport slave (
        input  start_i, S_selection_i, mode_control_i, carry_in_i, A_i, B_i,
        output ready_o, busy_o, done_o, F_o, carry_output_o, equality_o, zero_o
    );
    modport master (
        output start_i, S_selection_i, mode_control_i, carry_in_i, A_i, B_i,
        input  ready_o, busy_o, done_o, F_o, carry_output_o, equality_o, zero_o
    );
`endif
endinterface

// File: rtl/alu_181_serial.sv
// Multi-cycle 181-style ALU: WIDTH-bit operands processed one 4-bit slice per clock, LSB slice first.
// Optional signed-overflow flag enabled by defining ALU_181_OVF_EN.
module alu_181_serial #(
    parameter int WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    alu_181_serial_if.slave    bus
);
    localparam int SLICES = WIDTH / 4;
    localparam int KW     = (SLICES > 1) ? $clog2(SLICES) : 1;

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("alu_181_serial: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       s_q, s_d;
    logic             m_q, m_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, f_q, f_d;
    logic [KW-1:0]    k_q, k_d;
    logic             c_q, c_d;
    logic             co_q, co_d, eq_q, eq_d, zr_q, zr_d, ov_q, ov_d;

    // Slice datapath: operands of the current slice plus the rippled carry
    logic [3:0] a_sl, b_sl, x_sl, y_sl, lg_sl, f_sl;
    logic [4:0] sum5;
    logic [3:0] sum3;
    logic       c_nxt, ov_sl;

    always_comb begin
        a_sl = a_q[{k_q, 2'b00} +: 4];
        b_sl = b_q[{k_q, 2'b00} +: 4];
        x_sl = a_sl;
        y_sl = 4'h0;
        unique case (s_q)
            4'h0: begin x_sl = a_sl;          y_sl = 4'h0;          end
            4'h1: begin x_sl = a_sl | b_sl;   y_sl = 4'h0;          end
            4'h2: begin x_sl = a_sl | ~b_sl;  y_sl = 4'h0;          end
            4'h3: begin x_sl = 4'hF;          y_sl = 4'h0;          end
            4'h4: begin x_sl = a_sl;          y_sl = a_sl & ~b_sl;  end
            4'h5: begin x_sl = a_sl | b_sl;   y_sl = a_sl & ~b_sl;  end
            4'h6: begin x_sl = a_sl;          y_sl = ~b_sl;         end
            4'h7: begin x_sl = a_sl & ~b_sl;  y_sl = 4'hF;          end
            4'h8: begin x_sl = a_sl;          y_sl = a_sl & b_sl;   end
            4'h9: begin x_sl = a_sl;          y_sl = b_sl;          end
            4'hA: begin x_sl = a_sl | ~b_sl;  y_sl = a_sl & b_sl;   end
            4'hB: begin x_sl = a_sl & b_sl;   y_sl = 4'hF;          end
            4'hC: begin x_sl = a_sl;          y_sl = a_sl;          end
            4'hD: begin x_sl = a_sl | b_sl;   y_sl = a_sl;          end
            4'hE: begin x_sl = a_sl | ~b_sl;  y_sl = a_sl;          end
            default: begin x_sl = a_sl;       y_sl = 4'hF;          end
        endcase
        unique case (s_q)
            4'h0: lg_sl = ~a_sl;
            4'h1: lg_sl = ~(a_sl | b_sl);
            4'h2: lg_sl = ~a_sl & b_sl;
            4'h3: lg_sl = 4'h0;
            4'h4: lg_sl = ~(a_sl & b_sl);
            4'h5: lg_sl = ~b_sl;
            4'h6: lg_sl = a_sl ^ b_sl;
            4'h7: lg_sl = a_sl & ~b_sl;
            4'h8: lg_sl = ~a_sl | b_sl;
            4'h9: lg_sl = ~(a_sl ^ b_sl);
            4'hA: lg_sl = b_sl;
            4'hB: lg_sl = a_sl & b_sl;
            4'hC: lg_sl = 4'hF;
            4'hD: lg_sl = a_sl | ~b_sl;
            4'hE: lg_sl = a_sl | b_sl;
            default: lg_sl = a_sl;
        endcase
        sum5 = {1'b0, x_sl} + {1'b0, y_sl} + {4'b0, c_q};
        // Carry into the slice MSB, needed for signed overflow on the top slice
        sum3 = {1'b0, x_sl[2:0]} + {1'b0, y_sl[2:0]} + {3'b0, c_q};
        f_sl  = m_q ? lg_sl : sum5[3:0];
        c_nxt = m_q ? 1'b0 : sum5[4];
        ov_sl = m_q ? 1'b0 : (sum3[3] ^ sum5[4]);
    end

    always_comb begin
        state_d = state_q;
        s_d = s_q;  m_d = m_q;  a_d = a_q;  b_d = b_q;
        f_d = f_q;  k_d = k_q;  c_d = c_q;
        co_d = co_q;  eq_d = eq_q;  zr_d = zr_q;  ov_d = ov_q;
        unique case (state_q)
            IDLE: if (bus.start_i) begin
                s_d = bus.S_selection_i;
                m_d = bus.mode_control_i;
                a_d = bus.A_i;
                b_d = bus.B_i;
                c_d = bus.carry_in_i;
                f_d = '0;
                k_d = '0;
                co_d = 1'b0;  eq_d = 1'b0;  zr_d = 1'b0;  ov_d = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                f_d[{k_q, 2'b00} +: 4] = f_sl;
                c_d = c_nxt;
                k_d = k_q + 1'b1;
                if (k_q == KW'(SLICES - 1)) begin
                    co_d = c_nxt;
                    eq_d = &f_d;
                    zr_d = (f_d == '0);
                    ov_d = ov_sl;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            s_q <= '0;  m_q <= 1'b0;  a_q <= '0;  b_q <= '0;
            f_q <= '0;  k_q <= '0;    c_q <= 1'b0;
            co_q <= 1'b0;  eq_q <= 1'b0;  zr_q <= 1'b0;  ov_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q <= s_d;  m_q <= m_d;  a_q <= a_d;  b_q <= b_d;
            f_q <= f_d;  k_q <= k_d;  c_q <= c_d;
            co_q <= co_d;  eq_q <= eq_d;  zr_q <= zr_d;  ov_q <= ov_d;
        end
    end

    assign bus.ready_o        = (state_q == IDLE);
    assign bus.busy_o         = (state_q == RUN);
    assign bus.done_o         = (state_q == DONE);
    assign bus.F_o            = f_q;
    assign bus.carry_output_o = co_q;
    assign bus.equality_o     = eq_q;
    assign bus.zero_o         = zr_q;
`ifdef ALU_181_OVF_EN
    assign bus.overflow_o     = ov_q;
`else
    logic unused_ov;
    assign unused_ov = ov_q;
`endif
endmodule

// File: tb/tb_alu_181_serial.sv
// Self-checking bench for alu_181_serial: directed cases plus random ops against a full-width model.
module tb_alu_181_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_181_serial_if #(.WIDTH(16)) b16();
    alu_181_serial_if #(.WIDTH(4))  b4();

    alu_181_serial #(.WIDTH(16)) dut16 (.clk_i(clk), .rst_n_i(rst_n), .bus(b16.slave));
    alu_181_serial #(.WIDTH(4))  dut4  (.clk_i(clk), .rst_n_i(rst_n), .bus(b4.slave));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full-width reference: X + Y + Cn with plain integer arithmetic
    function automatic void ref_alu(input int w, input logic [3:0] s, input logic m, input logic cn,
                                    input longint unsigned a_in, input longint unsigned b_in,
                                    output longint unsigned f, output longint unsigned co,
                                    output longint unsigned ov);
        longint unsigned msk, a, b, nb, x, y, sum, lo, cmsb;
        msk = (64'd1 << w) - 1;
        a = a_in & msk;  b = b_in & msk;  nb = ~b & msk;
        co = 0;  ov = 0;  x = 0;  y = 0;  f = 0;
        if (m) begin
            case (s)
                4'h0: f = ~a;        4'h1: f = ~(a | b);  4'h2: f = ~a & b;   4'h3: f = 0;
                4'h4: f = ~(a & b);  4'h5: f = ~b;        4'h6: f = a ^ b;    4'h7: f = a & nb;
                4'h8: f = ~a | b;    4'h9: f = ~(a ^ b);  4'hA: f = b;        4'hB: f = a & b;
                4'hC: f = msk;       4'hD: f = a | nb;    4'hE: f = a | b;    default: f = a;
            endcase
            f = f & msk;
        end else begin
            case (s)
                4'h0: begin x = a;      y = 0;      end
                4'h1: begin x = a | b;  y = 0;      end
                4'h2: begin x = a | nb; y = 0;      end
                4'h3: begin x = msk;    y = 0;      end
                4'h4: begin x = a;      y = a & nb; end
                4'h5: begin x = a | b;  y = a & nb; end
                4'h6: begin x = a;      y = nb;     end
                4'h7: begin x = a & nb; y = msk;    end
                4'h8: begin x = a;      y = a & b;  end
                4'h9: begin x = a;      y = b;      end
                4'hA: begin x = a | nb; y = a & b;  end
                4'hB: begin x = a & b;  y = msk;    end
                4'hC: begin x = a;      y = a;      end
                4'hD: begin x = a | b;  y = a;      end
                4'hE: begin x = a | nb; y = a;      end
                default: begin x = a;   y = msk;    end
            endcase
            sum = x + y + longint'(cn);
            f = sum & msk;
            co = (sum >> w) & 1;
            lo = (64'd1 << (w - 1)) - 1;
            cmsb = (((x & lo) + (y & lo) + longint'(cn)) >> (w - 1)) & 1;
            ov = cmsb ^ co;
        end
    endfunction

    // One 16-bit op; poke re-pulses start mid-run, lit enables literal expected F/carry
    task automatic run16(input logic [3:0] s, input logic m, input logic cn,
                         input logic [15:0] a, input logic [15:0] b, input bit poke,
                         input bit lit, input logic [15:0] lf, input logic lco);
        longint unsigned ef, eco, eov;
        int cyc;
        ref_alu(16, s, m, cn, a, b, ef, eco, eov);
        @(negedge clk);
        chk("rdy16", b16.ready_o, 1);
        b16.S_selection_i = s;  b16.mode_control_i = m;  b16.carry_in_i = cn;
        b16.A_i = a;  b16.B_i = b;  b16.start_i = 1'b1;
        @(negedge clk);
        b16.start_i = 1'b0;
        chk("busy16", b16.busy_o, 1);
        b16.S_selection_i = 4'($urandom);  b16.mode_control_i = 1'($urandom);
        b16.carry_in_i = 1'($urandom);  b16.A_i = 16'($urandom);  b16.B_i = 16'($urandom);
        cyc = 0;
        while (b16.done_o !== 1'b1 && cyc < 20) begin
            b16.start_i = (poke && cyc == 1);
            @(negedge clk);
            cyc++;
        end
        b16.start_i = 1'b0;
        chk("lat16", 64'(cyc), 64'd4);
        chk("F16", b16.F_o, ef);
        chk("co16", b16.carry_output_o, eco);
        chk("eq16", b16.equality_o, (ef == 64'hFFFF) ? 1 : 0);
        chk("zero16", b16.zero_o, (ef == 0) ? 1 : 0);
`ifdef ALU_181_OVF_EN
        chk("ov16", b16.overflow_o, eov);
`endif
        if (lit) begin
            chk("litF16", b16.F_o, lf);
            chk("litco16", b16.carry_output_o, lco);
        end
        @(negedge clk);
        chk("done1cyc16", b16.done_o, 0);
        chk("hold16", b16.F_o, ef);
        chk("rdyback16", b16.ready_o, 1);
    endtask

    task automatic run4(input logic [3:0] s, input logic m, input logic cn,
                        input logic [3:0] a, input logic [3:0] b);
        longint unsigned ef, eco, eov;
        int cyc;
        ref_alu(4, s, m, cn, a, b, ef, eco, eov);
        @(negedge clk);
        b4.S_selection_i = s;  b4.mode_control_i = m;  b4.carry_in_i = cn;
        b4.A_i = a;  b4.B_i = b;  b4.start_i = 1'b1;
        @(negedge clk);
        b4.start_i = 1'b0;
        cyc = 0;
        while (b4.done_o !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("lat4", 64'(cyc), 64'd1);
        chk("F4", b4.F_o, ef);
        chk("co4", b4.carry_output_o, eco);
        chk("zero4", b4.zero_o, (ef == 0) ? 1 : 0);
`ifdef ALU_181_OVF_EN
        chk("ov4", b4.overflow_o, eov);
`endif
    endtask

    initial begin
        int dn;
        b16.start_i = 0; b16.S_selection_i = 0; b16.mode_control_i = 0; b16.carry_in_i = 0;
        b16.A_i = 0; b16.B_i = 0;
        b4.start_i = 0; b4.S_selection_i = 0; b4.mode_control_i = 0; b4.carry_in_i = 0;
        b4.A_i = 0; b4.B_i = 0;
        #12;
        chk("rst_ready", b16.ready_o, 1);
        chk("rst_busy", b16.busy_o, 0);
        chk("rst_done", b16.done_o, 0);
        chk("rst_F", b16.F_o, 0);
        chk("rst_co", b16.carry_output_o, 0);
        chk("rst_zero", b16.zero_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run16(4'h9, 0, 0, 16'h1234, 16'h0FCD, 0, 1, 16'h2201, 0);
        run16(4'h6, 0, 0, 16'h00A5, 16'h00A5, 0, 1, 16'hFFFF, 0);
        run16(4'h6, 0, 1, 16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0);
        run16(4'h9, 0, 1, 16'hFFFF, 16'h0000, 0, 1, 16'h0000, 1);
        run16(4'h6, 1, 1, 16'hF0F0, 16'hFF00, 0, 1, 16'h0FF0, 0);
        run16(4'h3, 1, 1, 16'hF0F0, 16'hFF00, 0, 1, 16'h0000, 0);
        run16(4'h9, 0, 0, 16'h7FFF, 16'h0001, 0, 1, 16'h8000, 0);
        run16(4'h9, 0, 0, 16'h1234, 16'h0FCD, 1, 1, 16'h2201, 0);

        for (int i = 0; i < 40; i++)
            run16(4'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 0, 0, 0, 0);

        run4(4'h9, 0, 0, 4'h3, 4'h4);
        for (int i = 0; i < 20; i++)
            run4(4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));

        // Abort two cycles into RUN
        @(negedge clk);
        b16.S_selection_i = 4'h9; b16.mode_control_i = 0; b16.carry_in_i = 0;
        b16.A_i = 16'h1111; b16.B_i = 16'h2222; b16.start_i = 1;
        @(negedge clk);
        b16.start_i = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", b16.busy_o, 0);
        chk("abort_ready", b16.ready_o, 1);
        chk("abort_F", b16.F_o, 0);
        chk("abort_done", b16.done_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b16.done_o === 1'b1) dn++;
        end
        chk("abort_nodone", 64'(dn), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
